servo_pwm_multi: RTL and testbench
==================================

Name: servo_pwm_multi

Overview:
- Parametrised N-channel servo PWM generator; successor to the single-channel angle-to-pulse mapper.
- Runs one shared microsecond timebase and one shared frame counter, with a per-channel target register written over a simple write port.
- Adds a per-channel slew limiter, glitch-free frame-boundary updates, angle clamping and a settled status.
- Sits between the arm motion controller and the servo pins.

Parameters:
- NUM_CH, 4, number of servo channels (1..16).
- CLK_HZ, 50_000_000, clock frequency; CLK_DIV = CLK_HZ/1_000_000 clocks per microsecond (≥1).
- SERVO_MIN_US, 500, pulse width at angle 0.
- SERVO_MAX_US, 2500, pulse width at angle 180.
- PERIOD_US, 20000, frame length in us.
- STEP_US, 20, max pulse-width change per frame per channel; 0 = no limiting (jump).
- RESET_ANGLE, 90, angle loaded into every target/current register at reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  run PWM; low = outputs idle.
- wr_en  in  1  write strobe; always accepted, no ready.
- wr_ch  in  4  channel index for the write.
- wr_angle  in  8  target angle, 0..180.
- pwm_out  out  NUM_CH  servo pulses, registered.
- settled  out  NUM_CH  1 when channel current width == target width.
- frame_start  out  1  one-clock pulse at the start of each frame.

Behaviour:
- Reset (rst=0, async):
  - pwm_out=0, frame_start=0, prescaler=0, us_cnt=0.
  - target_w[i] = cur_w[i] = width(RESET_ANGLE); settled = all ones.
- Width mapping: width(a) = SERVO_MIN_US + floor(a*(SERVO_MAX_US-SERVO_MIN_US)/180), computed at ≥20-bit precision, result 16 bit.
  - Angles >180 clamp to 180.
  - Examples: 0→500, 1→511, 45→1000, 90→1500, 180→2500, 255→2500.
- Write:
  - On a clk edge with wr_en=1 and wr_ch<NUM_CH, target_w[wr_ch] = width(wr_angle), visible the next cycle.
  - wr_ch≥NUM_CH is ignored silently.
  - Writes are accepted whether enable is high or low.
- Timebase:
  - With enable=1, the prescaler counts 0..CLK_DIV-1; us_tick is asserted when prescaler==CLK_DIV-1.
  - us_cnt advances on us_tick and wraps PERIOD_US-1→0. A frame is therefore exactly PERIOD_US*CLK_DIV clocks.
- Frame boundary (us_tick while us_cnt==PERIOD_US-1):
  - us_cnt←0 and frame_start=1 for that one clock.
  - For each channel, cur_w moves toward target_w by min(STEP_US, |target_w-cur_w|); with STEP_US=0, cur_w←target_w.
  - cur_w changes only here, so no pulse is ever truncated or doubled mid-frame.
  - A write on the same clock as the boundary is not used by that boundary's update; the slew step uses the pre-write target, and the new target is applied from the next boundary.
- Output: pwm_out[i] registered = enable && (us_cnt < cur_w[i]), one clock latency from the us_cnt change.
  - cur_w ≥ PERIOD_US gives a constant high; cannot occur with default parameters.
- settled[i] is combinational: cur_w[i]==target_w[i].
- enable=0:
  - prescaler and us_cnt are cleared synchronously; pwm_out=0 on the next clock; frame_start=0; cur_w frozen.
  - On enable rising, the frame restarts at us_cnt=0. The first frame has no frame_start pulse; the pulse first fires at its end.
- Reset mid-frame: immediate output low; targets are lost and return to RESET_ANGLE.

Test Plan:
- Mapping/clamp: CLK_HZ=1_000_000, STEP_US=0. Write ch0 angles 0, 45, 90, 180, 200, 255, each held one frame → measured high time 500, 1000, 1500, 2500, 2500, 2500 us (clocks). Period is exactly 20000 clocks.
- Slew: STEP_US=20, ch1 at 1500, write angle 180 → width rises 1520, 1540, … one step per frame and reaches 2500 after 50 frames. settled[1]=0 until that frame boundary, then 1.
- Boundary write race: write ch2 on the exact frame_start clock → the pulse in the following frame still uses the old cur_w. The change appears one frame later (STEP_US=0).
- Invalid channel/independence: NUM_CH=4, write wr_ch=7 → no target changes, settled stays all ones. Writing ch3 alone leaves ch0–2 pulses unchanged.
- Enable gating: drop enable mid-pulse → pwm_out low the next clock and us_cnt=0. Re-raise → the first pulse starts one clock later with full width, and frame_start fires PERIOD_US*CLK_DIV clocks after re-enable.
- Async reset: assert rst=0 mid-pulse between edges → pwm_out low immediately with no clock. After release, all channels pulse 1500 us and settled = all ones.

Source files
------------

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM generator: shared microsecond timebase and frame counter,
// per-channel angle targets with slew limiting applied only at frame boundaries.
module servo_pwm_multi #(
  parameter int NUM_CH       = 4,
  parameter int CLK_HZ       = 50_000_000,
  parameter int SERVO_MIN_US = 500,
  parameter int SERVO_MAX_US = 2500,
  parameter int PERIOD_US    = 20000,
  parameter int STEP_US      = 20,
  parameter int RESET_ANGLE  = 90
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic [7:0]        wr_angle,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] settled,
  output logic              frame_start
);

  localparam int              CLK_DIV  = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam int              PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [15:0]     US_LAST  = 16'(PERIOD_US - 1);
  localparam logic [31:0]     SPAN     = 32'(SERVO_MAX_US - SERVO_MIN_US);
  localparam logic [15:0]     STEP     = 16'(STEP_US);

  // Angle to pulse width in us; angles past 180 clamp, product kept at 32 bits.
  function automatic logic [15:0] width_of(input logic [7:0] angle);
    logic [31:0] a;
    a = (angle > 8'd180) ? 32'd180 : {24'd0, angle};
    return 16'(32'(SERVO_MIN_US) + (a * SPAN) / 32'd180);
  endfunction

  function automatic logic [15:0] slew(input logic [15:0] cur, input logic [15:0] tgt);
    if (STEP_US == 0) return tgt;
    if (tgt > cur) return ((tgt - cur) > STEP) ? cur + STEP : tgt;
    return ((cur - tgt) > STEP) ? cur - STEP : tgt;
  endfunction

  localparam logic [15:0] RESET_W = width_of(8'(RESET_ANGLE));

  logic [PW-1:0] prescaler;
  logic [15:0]   us_cnt;
  logic          us_tick;
  logic          frame_end;
  logic [15:0]   target_w [NUM_CH];
  logic [15:0]   cur_w    [NUM_CH];

  assign us_tick   = enable && (prescaler == PRE_LAST);
  assign frame_end = us_tick && (us_cnt == US_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler   <= '0;
      us_cnt      <= '0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      prescaler   <= '0;
      us_cnt      <= '0;
      frame_start <= 1'b0;
    end else begin
      prescaler   <= us_tick ? '0 : prescaler + PW'(1);
      frame_start <= frame_end;
      if (us_tick) us_cnt <= frame_end ? '0 : us_cnt + 16'd1;
    end
  end

  // cur_w samples the pre-write target, so a write landing on a boundary waits a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        target_w[i] <= RESET_W;
        cur_w[i]    <= RESET_W;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (frame_end) cur_w[i] <= slew(cur_w[i], target_w[i]);
        if (wr_en && (wr_ch == 4'(i))) target_w[i] <= width_of(wr_angle);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) pwm_out[i] <= enable && (us_cnt < cur_w[i]);
    end
  end

  always_comb begin
    settled = '0;
    for (int i = 0; i < NUM_CH; i++) settled[i] = (cur_w[i] == target_w[i]);
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi: a jump-mode instance (1 MHz) and a slewing
// instance (2 MHz, narrow servo range) driven from one clock and shared reset/enable.
module tb_servo_pwm_multi;

  localparam int P_A = 2600;  // clocks per frame, instance A
  localparam int P_B = 2400;  // clocks per frame, instance B (1200 us at 2 clocks/us)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       wr_en_a = 1'b0;
  logic       wr_en_b = 1'b0;
  logic [3:0] wr_ch = 4'd0;
  logic [7:0] wr_angle = 8'd0;
  logic [3:0] pwm_a, settled_a;
  logic [1:0] pwm_b, settled_b;
  logic       frame_start_a, frame_start_b;

  int   tests = 0;
  int   fails = 0;
  int   hi_a [4];
  int   hi_b [2];
  int   fs_cnt_a, fs_cnt_b, fs_edge_a, fs_edge_b;
  logic last_fs_a, last_fs_b, first_pwm_a;
  bit   ok;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .NUM_CH(4), .CLK_HZ(1_000_000), .SERVO_MIN_US(500), .SERVO_MAX_US(2500),
    .PERIOD_US(2600), .STEP_US(0), .RESET_ANGLE(90)
  ) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en_a), .wr_ch(wr_ch),
    .wr_angle(wr_angle), .pwm_out(pwm_a), .settled(settled_a), .frame_start(frame_start_a)
  );

  servo_pwm_multi #(
    .NUM_CH(2), .CLK_HZ(2_000_000), .SERVO_MIN_US(100), .SERVO_MAX_US(1000),
    .PERIOD_US(1200), .STEP_US(200), .RESET_ANGLE(90)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en_b), .wr_ch(wr_ch),
    .wr_angle(wr_angle), .pwm_out(pwm_b), .settled(settled_b), .frame_start(frame_start_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input bit sel_b, output bit found);
    found = 1'b0;
    for (int n = 0; n < 6000 && !found; n++) begin
      tick();
      found = sel_b ? frame_start_b : frame_start_a;
    end
  endtask

  // Counts high clocks per channel over n_edges, optionally writing on the first edge.
  task automatic measure_frame(input int n_edges, input bit do_wr_a, input bit do_wr_b,
                               input logic [3:0] ch, input logic [7:0] ang);
    for (int i = 0; i < 4; i++) hi_a[i] = 0;
    for (int i = 0; i < 2; i++) hi_b[i] = 0;
    fs_cnt_a = 0;
    fs_cnt_b = 0;
    wr_ch    = ch;
    wr_angle = ang;
    wr_en_a  = do_wr_a;
    wr_en_b  = do_wr_b;
    for (int n = 0; n < n_edges; n++) begin
      tick();
      wr_en_a = 1'b0;
      wr_en_b = 1'b0;
      for (int i = 0; i < 4; i++) if (pwm_a[i]) hi_a[i]++;
      for (int i = 0; i < 2; i++) if (pwm_b[i]) hi_b[i]++;
      if (frame_start_a) fs_cnt_a++;
      if (frame_start_b) fs_cnt_b++;
      last_fs_a = frame_start_a;
      last_fs_b = frame_start_b;
    end
  endtask

  // Raises enable and measures the first frame of both instances.
  task automatic start_and_measure();
    for (int i = 0; i < 4; i++) hi_a[i] = 0;
    for (int i = 0; i < 2; i++) hi_b[i] = 0;
    fs_edge_a = 0;
    fs_edge_b = 0;
    enable = 1'b1;
    for (int n = 1; n <= P_A + 4; n++) begin
      tick();
      if (n == 1) first_pwm_a = pwm_a[0];
      if (n <= P_A) for (int i = 0; i < 4; i++) if (pwm_a[i]) hi_a[i]++;
      if (n <= P_B) for (int i = 0; i < 2; i++) if (pwm_b[i]) hi_b[i]++;
      if (frame_start_a && fs_edge_a == 0) fs_edge_a = n;
      if (frame_start_b && fs_edge_b == 0) fs_edge_b = n;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    tests++; if (pwm_a !== 4'h0) begin fails++; $display("[TB] FAIL reset_pwm_a: got %h expected 0", pwm_a); end
    tests++; if (pwm_b !== 2'h0) begin fails++; $display("[TB] FAIL reset_pwm_b: got %h expected 0", pwm_b); end
    tests++; if (frame_start_a !== 1'b0) begin fails++; $display("[TB] FAIL reset_fs: got %b expected 0", frame_start_a); end
    tests++; if (settled_a !== 4'hF) begin fails++; $display("[TB] FAIL reset_settled_a: got %h expected f", settled_a); end
    tests++; if (settled_b !== 2'h3) begin fails++; $display("[TB] FAIL reset_settled_b: got %h expected 3", settled_b); end
    tick();
    rst = 1'b1;
    repeat (3) tick();
    tests++; if (pwm_a !== 4'h0) begin fails++; $display("[TB] FAIL idle_pwm_a: got %h expected 0", pwm_a); end
  endtask

  task automatic test_enable_start();
    start_and_measure();
    tests++; if (fs_edge_a != P_A) begin fails++; $display("[TB] FAIL first_fs_a: got %0d expected %0d", fs_edge_a, P_A); end
    tests++; if (fs_edge_b != P_B) begin fails++; $display("[TB] FAIL first_fs_b: got %0d expected %0d", fs_edge_b, P_B); end
    tests++; if (first_pwm_a !== 1'b1) begin fails++; $display("[TB] FAIL first_pwm_edge: got %b expected 1", first_pwm_a); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (hi_a[i] != 1500) begin fails++; $display("[TB] FAIL start_width_a ch%0d: got %0d expected 1500", i, hi_a[i]); end
    end
    tests++; if (hi_b[0] != 1100) begin fails++; $display("[TB] FAIL start_width_b: got %0d expected 1100", hi_b[0]); end
  endtask

  task automatic test_mapping();
    logic [7:0] angles [6] = '{8'd0, 8'd45, 8'd90, 8'd180, 8'd200, 8'd255};
    int         exp_w  [6] = '{500, 1000, 1500, 2500, 2500, 2500};
    wait_fs(1'b0, ok);
    tests++; if (!ok) begin fails++; $display("[TB] FAIL map_sync: got timeout expected frame_start"); end
    measure_frame(P_A, 1'b1, 1'b0, 4'd0, angles[0]);
    for (int i = 0; i < 6; i++) begin
      measure_frame(P_A, (i < 5), 1'b0, 4'd0, (i < 5) ? angles[(i < 5) ? i + 1 : 0] : 8'd0);
      tests++; if (hi_a[0] != exp_w[i]) begin fails++; $display("[TB] FAIL map_angle_%0d: got %0d expected %0d", angles[i], hi_a[0], exp_w[i]); end
      tests++; if (fs_cnt_a != 1 || last_fs_a !== 1'b1) begin fails++; $display("[TB] FAIL map_period: got %0d pulses last=%b expected 1 at clock %0d", fs_cnt_a, last_fs_a, P_A); end
      if (i == 0) begin
        tests++; if (hi_a[1] != 1500 || hi_a[3] != 1500) begin fails++; $display("[TB] FAIL map_others: got %0d/%0d expected 1500/1500", hi_a[1], hi_a[3]); end
      end
    end
  endtask

  task automatic test_invalid_channel();
    wr_en_a = 1'b1; wr_ch = 4'd7; wr_angle = 8'd0;
    tick();
    wr_ch = 4'd4;
    tick();
    wr_en_a = 1'b0;
    tests++; if (settled_a !== 4'hF) begin fails++; $display("[TB] FAIL invalid_ch_settled: got %h expected f", settled_a); end
    wr_en_a = 1'b1; wr_ch = 4'd3; wr_angle = 8'd45;
    tick();
    wr_en_a = 1'b0;
    tests++; if (settled_a !== 4'b0111) begin fails++; $display("[TB] FAIL ch3_write_settled: got %h expected 7", settled_a); end
    wait_fs(1'b0, ok);
    tests++; if (!ok || settled_a !== 4'hF) begin fails++; $display("[TB] FAIL ch3_boundary_settled: got %h ok=%b expected f", settled_a, ok); end
    measure_frame(P_A, 1'b0, 1'b0, 4'd0, 8'd0);
    tests++; if (hi_a[0] != 2500) begin fails++; $display("[TB] FAIL indep_ch0: got %0d expected 2500", hi_a[0]); end
    tests++; if (hi_a[1] != 1500 || hi_a[2] != 1500) begin fails++; $display("[TB] FAIL indep_ch12: got %0d/%0d expected 1500/1500", hi_a[1], hi_a[2]); end
    tests++; if (hi_a[3] != 1000) begin fails++; $display("[TB] FAIL indep_ch3: got %0d expected 1000", hi_a[3]); end
  endtask

  // Write to ch2 lands on the very edge where the frame boundary update happens.
  task automatic test_back_to_back();
    repeat (P_A - 1) tick();
    wr_en_a = 1'b1; wr_ch = 4'd2; wr_angle = 8'd0;
    tick();
    wr_en_a = 1'b0;
    tests++; if (frame_start_a !== 1'b1) begin fails++; $display("[TB] FAIL race_align: got %b expected 1", frame_start_a); end
    tests++; if (settled_a[2] !== 1'b0) begin fails++; $display("[TB] FAIL race_settled: got %b expected 0", settled_a[2]); end
    measure_frame(P_A, 1'b0, 1'b0, 4'd0, 8'd0);
    tests++; if (hi_a[2] != 1500) begin fails++; $display("[TB] FAIL race_old_width: got %0d expected 1500", hi_a[2]); end
    tests++; if (settled_a !== 4'hF) begin fails++; $display("[TB] FAIL race_next_settled: got %h expected f", settled_a); end
    measure_frame(P_A, 1'b0, 1'b0, 4'd0, 8'd0);
    tests++; if (hi_a[2] != 500) begin fails++; $display("[TB] FAIL race_new_width: got %0d expected 500", hi_a[2]); end
  endtask

  // Instance B: 550 us -> 1000 us in steps of 200 (750, 950, then a 50 us remainder).
  task automatic test_slew();
    int exp_hi  [3] = '{1500, 1900, 2000};
    logic exp_s [3] = '{1'b0, 1'b1, 1'b1};
    wait_fs(1'b1, ok);
    tests++; if (!ok) begin fails++; $display("[TB] FAIL slew_sync: got timeout expected frame_start"); end
    wr_en_b = 1'b1; wr_ch = 4'd1; wr_angle = 8'd180;
    tick();
    wr_en_b = 1'b0;
    tests++; if (settled_b !== 2'b01) begin fails++; $display("[TB] FAIL slew_write_settled: got %b expected 01", settled_b); end
    wait_fs(1'b1, ok);
    tests++; if (!ok || settled_b[1] !== 1'b0) begin fails++; $display("[TB] FAIL slew_first_step: got %b ok=%b expected 0", settled_b[1], ok); end
    for (int f = 0; f < 3; f++) begin
      measure_frame(P_B, 1'b0, 1'b0, 4'd0, 8'd0);
      tests++; if (hi_b[1] != exp_hi[f]) begin fails++; $display("[TB] FAIL slew_width_f%0d: got %0d expected %0d", f, hi_b[1], exp_hi[f]); end
      tests++; if (settled_b[1] !== exp_s[f]) begin fails++; $display("[TB] FAIL slew_settled_f%0d: got %b expected %b", f, settled_b[1], exp_s[f]); end
      tests++; if (hi_b[0] != 1100 || fs_cnt_b != 1 || last_fs_b !== 1'b1) begin fails++; $display("[TB] FAIL slew_ch0_period_f%0d: got %0d/%0d/%b expected 1100/1/1", f, hi_b[0], fs_cnt_b, last_fs_b); end
    end
  endtask

  task automatic test_enable_gating();
    wait_fs(1'b0, ok);
    repeat (100) tick();
    tests++; if (!ok || pwm_a[0] !== 1'b1) begin fails++; $display("[TB] FAIL gate_mid_pulse: got %b ok=%b expected 1", pwm_a[0], ok); end
    enable = 1'b0;
    tick();
    tests++; if (pwm_a !== 4'h0 || pwm_b !== 2'h0) begin fails++; $display("[TB] FAIL gate_off: got %h/%h expected 0/0", pwm_a, pwm_b); end
    wr_en_a = 1'b1; wr_ch = 4'd0; wr_angle = 8'd90;
    tick();
    wr_en_a = 1'b0;
    tests++; if (settled_a !== 4'b1110) begin fails++; $display("[TB] FAIL gate_write: got %h expected e", settled_a); end
    repeat (3) tick();
    tests++; if (pwm_a !== 4'h0 || frame_start_a !== 1'b0) begin fails++; $display("[TB] FAIL gate_idle: got %h fs=%b expected 0", pwm_a, frame_start_a); end
    start_and_measure();
    tests++; if (fs_edge_a != P_A) begin fails++; $display("[TB] FAIL regate_fs: got %0d expected %0d", fs_edge_a, P_A); end
    tests++; if (first_pwm_a !== 1'b1) begin fails++; $display("[TB] FAIL regate_first_edge: got %b expected 1", first_pwm_a); end
    tests++; if (hi_a[0] != 2500) begin fails++; $display("[TB] FAIL regate_frozen_ch0: got %0d expected 2500", hi_a[0]); end
    tests++; if (hi_a[2] != 500 || hi_a[3] != 1000) begin fails++; $display("[TB] FAIL regate_ch23: got %0d/%0d expected 500/1000", hi_a[2], hi_a[3]); end
    tests++; if (settled_a !== 4'hF) begin fails++; $display("[TB] FAIL regate_settled: got %h expected f", settled_a); end
  endtask

  task automatic test_async_reset();
    wait_fs(1'b0, ok);
    repeat (10) tick();
    #2 rst = 1'b0;
    #1;
    tests++; if (!ok || pwm_a !== 4'h0 || pwm_b !== 2'h0) begin fails++; $display("[TB] FAIL async_pwm: got %h/%h ok=%b expected 0/0", pwm_a, pwm_b, ok); end
    tests++; if (settled_a !== 4'hF || settled_b !== 2'h3) begin fails++; $display("[TB] FAIL async_settled: got %h/%h expected f/3", settled_a, settled_b); end
    enable = 1'b0;
    tick();
    rst = 1'b1;
    start_and_measure();
    for (int i = 0; i < 4; i++) begin
      tests++; if (hi_a[i] != 1500) begin fails++; $display("[TB] FAIL post_reset_ch%0d: got %0d expected 1500", i, hi_a[i]); end
    end
    tests++; if (hi_b[1] != 1100) begin fails++; $display("[TB] FAIL post_reset_b: got %0d expected 1100", hi_b[1]); end
    tests++; if (fs_edge_a != P_A) begin fails++; $display("[TB] FAIL post_reset_fs: got %0d expected %0d", fs_edge_a, P_A); end
  endtask

  initial begin
    test_reset();
    test_enable_start();
    test_mapping();
    test_invalid_channel();
    test_back_to_back();
    test_slew();
    test_enable_gating();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
